// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, constants and the fetch buffer entry type
package fetch_unit_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two circular buffer with push, pop, sync clear and occupancy count
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign head  = mem[rd_ptr];
    assign empty = count == '0;
    always_ff @(posedge clock) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // upstream credit accounting must never let a push land on a full buffer
    assert property (@(posedge clock) disable iff (reset || clear) !(push && count == CW'(DEPTH)));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential PC fetch with credit-limited requests, response buffering and redirect flush
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic [XLEN-1:0] fetch_pc, resp_pc, redirect_target;
    logic [CW-1:0] outstanding, drop, count;
    logic empty, req_fire, push, pop;
    fetch_entry_t push_entry, head;
    assign redirect_target = redirect_pc & ~32'h3;
    // live in-flight words plus buffered words must fit in the buffer
    assign imem_req_valid = !reset && !redirect_valid &&
        (({1'b0, count} + {1'b0, outstanding} - {1'b0, drop}) < (CW + 1)'(FIFO_DEPTH));
    assign imem_req_addr = fetch_pc;
    assign req_fire = imem_req_valid && imem_req_ready;
    assign push = imem_resp_valid && drop == '0 && !redirect_valid;
    assign out_valid = !reset && !empty && !redirect_valid;
    assign pop = out_valid && out_ready;
    assign push_entry = '{pc: resp_pc, instr: imem_resp_data};
    assign out_pc = head.pc;
    assign out_instr = head.instr;
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
        .clock(clock),
        .reset(reset),
        .clear(redirect_valid),
        .push(push),
        .pop(pop),
        .push_data(push_entry),
        .head(head),
        .count(count),
        .empty(empty)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_target;
            resp_pc     <= redirect_target;
            outstanding <= outstanding - CW'(imem_resp_valid);
            drop        <= outstanding - CW'(imem_resp_valid);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (push) resp_pc <= resp_pc + 32'd4;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (imem_resp_valid && drop != '0) drop <= drop - CW'(1);
        end
    end
endmodule
